// File: rtl/io_responder_if.sv
// Bus bundle between the PC-stage requester, the IO device and memory.
interface io_responder_if;
  localparam int unsigned MD_W   = 16;
  localparam int unsigned ADDR_W = 13;
  localparam int unsigned DATA_W = 32;

  logic              IOrequest;
  logic              io_dir;
  logic [MD_W-1:0]   move_data;
  logic [DATA_W-1:0] mem_rdata;
  logic              dev_req;
  logic              dev_we;
  logic [ADDR_W-1:0] dev_addr;
  logic [DATA_W-1:0] dev_wdata;
  logic              dev_ack;
  logic [DATA_W-1:0] dev_rdata;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic              busy;
  logic              done;
  logic              err;
  logic              overrun;

  // Responder side
  modport slave (
    input  IOrequest, io_dir, move_data, mem_rdata, dev_ack, dev_rdata,
    output dev_req, dev_we, dev_addr, dev_wdata, mem_we, mem_wdata,
           busy, done, err, overrun
  );

  // Requester / device side
  modport master (
    output IOrequest, io_dir, move_data, mem_rdata, dev_ack, dev_rdata,
    input  dev_req, dev_we, dev_addr, dev_wdata, mem_we, mem_wdata,
           busy, done, err, overrun
  );
endinterface

// File: rtl/io_responder.sv
// IO transfer responder: validates an IO address, runs one device handshake
// with timeout, reports completion, and parks one extra request while busy.
module io_responder #(
  parameter int unsigned TIMEOUT = 15
) (
  input logic          clk,
  input logic          rst_n,
  io_responder_if.slave bus
);
  localparam int unsigned CNT_W  = 8;
  localparam int unsigned MD_W   = 16;
  localparam int unsigned ADDR_W = 13;
  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {IDLE, REQ, CPL} state_t;

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic               cur_dir, cur_dir_n;
  logic               slot_full, slot_full_n;
  logic               slot_dir, slot_dir_n;
  logic [MD_W-1:0]    slot_md, slot_md_n;
  logic [DATA_W-1:0]  slot_data, slot_data_n;

  logic               dev_req_q, dev_req_n;
  logic               dev_we_q, dev_we_n;
  logic [ADDR_W-1:0]  dev_addr_q, dev_addr_n;
  logic [DATA_W-1:0]  dev_wdata_q, dev_wdata_n;
  logic               mem_we_q, mem_we_n;
  logic [DATA_W-1:0]  mem_wdata_q, mem_wdata_n;
  logic               busy_q, busy_n;
  logic               done_q, done_n;
  logic               err_q, err_n;
  logic               overrun_q, overrun_n;

  logic               src_go, src_dir, take_input;
  logic [MD_W-1:0]    src_md;
  logic [DATA_W-1:0]  src_data;

  // Next-state and next-output logic
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    cur_dir_n   = cur_dir;
    slot_full_n = slot_full;
    slot_dir_n  = slot_dir;
    slot_md_n   = slot_md;
    slot_data_n = slot_data;
    dev_req_n   = dev_req_q;
    dev_we_n    = dev_we_q;
    dev_addr_n  = dev_addr_q;
    dev_wdata_n = dev_wdata_q;
    mem_wdata_n = mem_wdata_q;
    mem_we_n    = 1'b0;
    done_n      = 1'b0;
    err_n       = 1'b0;
    overrun_n   = overrun_q;
    src_go      = 1'b0;
    take_input  = 1'b0;
    src_dir     = bus.io_dir;
    src_md      = bus.move_data;
    src_data    = bus.mem_rdata;

    case (state)
      IDLE: begin
        if (bus.IOrequest) begin
          src_go     = 1'b1;
          take_input = 1'b1;
        end
      end
      REQ: begin
        if (bus.dev_ack) begin
          state_n   = CPL;
          dev_req_n = 1'b0;
          done_n    = 1'b1;
          if (!cur_dir) begin
            mem_we_n    = 1'b1;
            mem_wdata_n = bus.dev_rdata;
          end
        end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
          state_n   = CPL;
          dev_req_n = 1'b0;
          done_n    = 1'b1;
          err_n     = 1'b1;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      CPL: begin
        if (slot_full) begin
          src_go      = 1'b1;
          src_dir     = slot_dir;
          src_md      = slot_md;
          src_data    = slot_data;
          slot_full_n = 1'b0;
        end else if (bus.IOrequest) begin
          // Empty slot: the new request passes straight through it.
          src_go     = 1'b1;
          take_input = 1'b1;
        end else begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase

    // Start a transfer or reject a bad address
    if (src_go) begin
      if (src_md[15] && (src_md[1:0] == 2'b00)) begin
        state_n     = REQ;
        cnt_n       = '0;
        cur_dir_n   = src_dir;
        dev_req_n   = 1'b1;
        dev_we_n    = src_dir;
        dev_addr_n  = src_md[14:2];
        dev_wdata_n = src_data;
      end else begin
        state_n = CPL;
        done_n  = 1'b1;
        err_n   = 1'b1;
      end
    end

    // Park a request arriving while busy, or drop it
    if (bus.IOrequest && !take_input) begin
      if (!slot_full_n) begin
        slot_full_n = 1'b1;
        slot_dir_n  = bus.io_dir;
        slot_md_n   = bus.move_data;
        slot_data_n = bus.mem_rdata;
      end else begin
        overrun_n = 1'b1;
      end
    end

    busy_n = (state_n != IDLE) || slot_full_n;
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      cur_dir     <= 1'b0;
      slot_full   <= 1'b0;
      slot_dir    <= 1'b0;
      slot_md     <= '0;
      slot_data   <= '0;
      dev_req_q   <= 1'b0;
      dev_we_q    <= 1'b0;
      dev_addr_q  <= '0;
      dev_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      cur_dir     <= cur_dir_n;
      slot_full   <= slot_full_n;
      slot_dir    <= slot_dir_n;
      slot_md     <= slot_md_n;
      slot_data   <= slot_data_n;
      dev_req_q   <= dev_req_n;
      dev_we_q    <= dev_we_n;
      dev_addr_q  <= dev_addr_n;
      dev_wdata_q <= dev_wdata_n;
      mem_we_q    <= mem_we_n;
      mem_wdata_q <= mem_wdata_n;
      busy_q      <= busy_n;
      done_q      <= done_n;
      err_q       <= err_n;
      overrun_q   <= overrun_n;
    end
  end

  assign bus.dev_req   = dev_req_q;
  assign bus.dev_we    = dev_we_q;
  assign bus.dev_addr  = dev_addr_q;
  assign bus.dev_wdata = dev_wdata_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.overrun   = overrun_q;
endmodule

// File: tb/tb_io_responder.sv
// Bench for io_responder: directed scenarios plus random traffic, all outputs
// checked every cycle against a transaction-level reference model.
module tb_io_responder;
  localparam int unsigned TIMEOUT = 15;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  io_responder_if bus ();

  io_responder #(.TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: one transfer at the device, a wait list of at most one.
  typedef struct {
    bit        dir;
    bit [15:0] md;
    bit [31:0] data;
  } xfer_t;

  xfer_t     m_wait[$];
  bit        m_dev_req, m_dev_we, m_dir;
  bit [12:0] m_addr;
  bit [31:0] m_wdata, m_mem_wdata;
  bit        m_mem_we, m_done, m_err, m_overrun, m_busy;
  int        m_held;

  function automatic void model_reset();
    m_wait.delete();
    m_dev_req = 0; m_dev_we = 0; m_dir = 0; m_addr = '0; m_wdata = '0;
    m_mem_wdata = '0; m_mem_we = 0; m_done = 0; m_err = 0; m_overrun = 0;
    m_busy = 0; m_held = 0;
  endfunction

  function automatic void model_start(xfer_t x);
    if (x.md[15] && x.md[1:0] == 2'b00) begin
      m_dev_req = 1; m_dev_we = x.dir; m_dir = x.dir;
      m_addr = x.md[14:2]; m_wdata = x.data; m_held = 0;
    end else begin
      m_done = 1; m_err = 1;
    end
  endfunction

  function automatic void model_step(bit req, bit dir, bit [15:0] md,
                                     bit [31:0] mdata, bit ack, bit [31:0] rdata);
    xfer_t inq;
    bit    consumed;
    inq = '{dir: dir, md: md, data: mdata};
    consumed = 0;
    m_done = 0; m_err = 0; m_mem_we = 0;
    if (m_dev_req) begin
      m_held++;
      if (ack) begin
        m_dev_req = 0; m_done = 1;
        if (!m_dir) begin m_mem_we = 1; m_mem_wdata = rdata; end
      end else if (m_held == int'(TIMEOUT)) begin
        m_dev_req = 0; m_done = 1; m_err = 1;
      end
    end else begin
      if (m_wait.size() > 0) model_start(m_wait.pop_front());
      else if (req) begin consumed = 1; model_start(inq); end
    end
    if (req && !consumed) begin
      if (m_wait.size() == 0) m_wait.push_back(inq);
      else m_overrun = 1;
    end
    m_busy = m_dev_req || m_done || (m_wait.size() > 0);
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison of DUT outputs against the model
  task automatic compare_all();
    chk("dev_req",   32'(bus.dev_req),   32'(m_dev_req));
    chk("done",      32'(bus.done),      32'(m_done));
    chk("err",       32'(bus.err),       32'(m_err));
    chk("mem_we",    32'(bus.mem_we),    32'(m_mem_we));
    chk("mem_wdata", bus.mem_wdata,      m_mem_wdata);
    chk("busy",      32'(bus.busy),      32'(m_busy));
    chk("overrun",   32'(bus.overrun),   32'(m_overrun));
    if (m_dev_req) begin
      chk("dev_we",    32'(bus.dev_we),   32'(m_dev_we));
      chk("dev_addr",  32'(bus.dev_addr), 32'(m_addr));
      chk("dev_wdata", bus.dev_wdata,     m_wdata);
    end
  endtask

  task automatic chk_all_zero(string tag);
    chk({tag, "_dev_req"},   32'(bus.dev_req),   32'h0);
    chk({tag, "_dev_we"},    32'(bus.dev_we),    32'h0);
    chk({tag, "_dev_addr"},  32'(bus.dev_addr),  32'h0);
    chk({tag, "_dev_wdata"}, bus.dev_wdata,      32'h0);
    chk({tag, "_mem_we"},    32'(bus.mem_we),    32'h0);
    chk({tag, "_mem_wdata"}, bus.mem_wdata,      32'h0);
    chk({tag, "_done"},      32'(bus.done),      32'h0);
    chk({tag, "_err"},       32'(bus.err),       32'h0);
    chk({tag, "_overrun"},   32'(bus.overrun),   32'h0);
    chk({tag, "_busy"},      32'(bus.busy),      32'h0);
  endtask

  // One clock: drive inputs, step model at the edge, compare at negedge
  task automatic cyc(bit req, bit dir, bit [15:0] md, bit [31:0] mdata,
                     bit ack, bit [31:0] rdata);
    bus.IOrequest = req; bus.io_dir = dir; bus.move_data = md;
    bus.mem_rdata = mdata; bus.dev_ack = ack; bus.dev_rdata = rdata;
    @(posedge clk);
    model_step(req, dir, md, mdata, ack, rdata);
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle_cyc();
    cyc(1'b0, 1'b0, 16'h0, 32'h0, 1'b0, 32'h0);
  endtask

  // Asynchronous reset between edges; requests during reset must be ignored
  task automatic do_reset(string tag);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero(tag);
    model_reset();
    bus.IOrequest = 1'b1; bus.move_data = 16'h8010; bus.dev_ack = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_held_req"},  32'(bus.dev_req), 32'h0);
    chk({tag, "_held_done"}, 32'(bus.done),    32'h0);
    bus.IOrequest = 1'b0; bus.dev_ack = 1'b0;
    rst_n = 1'b1;
  endtask

  initial begin
    int    dones, highs;
    bit    req, ack, dir;
    bit [15:0] md;
    int    ack_div;

    n_cmp = 0; n_bad = 0;
    rst_n = 1'b0;
    bus.IOrequest = 1'b0; bus.io_dir = 1'b0; bus.move_data = '0;
    bus.mem_rdata = '0; bus.dev_ack = 1'b0; bus.dev_rdata = '0;
    model_reset();
    repeat (3) @(negedge clk);
    chk_all_zero("rst");
    rst_n = 1'b1;

    // Read from IO, ack one cycle after dev_req rises: done 3 cycles later
    cyc(1, 0, 16'h8010, 32'h0, 0, 32'h0);
    chk("r036_addr", 32'(bus.dev_addr), 32'h0004);
    chk("r036_we",   32'(bus.dev_we),   32'h0);
    chk("r036_maddr", 32'(m_addr),      32'h0004);
    cyc(0, 0, 16'h0, 32'h0, 0, 32'h0);
    chk("r036_nodone", 32'(bus.done), 32'h0);
    cyc(0, 0, 16'h0, 32'h0, 1, 32'hCAFE0001);
    chk("r036_done",  32'(bus.done),   32'h1);
    chk("r036_memwe", 32'(bus.mem_we), 32'h1);
    chk("r036_wdata", bus.mem_wdata,   32'hCAFE0001);
    chk("r036_mdone", 32'(m_done),     32'h1);
    idle_cyc();

    // Write to IO at the top address, ack after two waiting cycles
    cyc(1, 1, 16'hFFFC, 32'h12345678, 0, 32'h0);
    chk("r037_we",    32'(bus.dev_we),   32'h1);
    chk("r037_addr",  32'(bus.dev_addr), 32'h1FFF);
    chk("r037_wdata", bus.dev_wdata,     32'h12345678);
    cyc(0, 0, 16'h0, 32'h0, 0, 32'h0);
    cyc(0, 0, 16'h0, 32'h0, 0, 32'h0);
    cyc(0, 0, 16'h0, 32'h0, 1, 32'hDEADBEEF);
    chk("r037_done",  32'(bus.done),   32'h1);
    chk("r037_memwe", 32'(bus.mem_we), 32'h0);
    chk("r037_hold",  bus.mem_wdata,   32'hCAFE0001);
    idle_cyc();

    // Rejected addresses: below IO space and misaligned
    cyc(1, 0, 16'h7FFC, 32'h0, 0, 32'h0);
    chk("r038a_done", 32'(bus.done),    32'h1);
    chk("r038a_err",  32'(bus.err),     32'h1);
    chk("r038a_req",  32'(bus.dev_req), 32'h0);
    cyc(1, 0, 16'h8002, 32'h0, 0, 32'h0);
    chk("r038b_done", 32'(bus.done),    32'h1);
    chk("r038b_err",  32'(bus.err),     32'h1);
    chk("r038b_req",  32'(bus.dev_req), 32'h0);
    idle_cyc();

    // Ack in the first dev_req cycle: done two cycles after the request
    cyc(1, 0, 16'h8020, 32'h0, 0, 32'h0);
    cyc(0, 0, 16'h0, 32'h0, 1, 32'h0000_0A0A);
    chk("k0_done", 32'(bus.done), 32'h1);
    idle_cyc();

    // Timeout: dev_req held exactly TIMEOUT cycles, then err
    highs = 0;
    cyc(1, 1, 16'h8000, 32'h5, 0, 32'h0);
    for (int i = 0; i < 20 && !bus.done; i++) begin
      if (bus.dev_req) highs++;
      cyc(0, 0, 16'h0, 32'h0, 0, 32'h0);
    end
    chk("r039_highs", 32'(highs),     32'(TIMEOUT));
    chk("r039_err",   32'(bus.err),   32'h1);
    idle_cyc();
    // Ack on the final counted cycle wins
    cyc(1, 0, 16'h8000, 32'h0, 0, 32'h0);
    for (int i = 0; i < int'(TIMEOUT) - 1; i++) cyc(0, 0, 16'h0, 32'h0, 0, 32'h0);
    cyc(0, 0, 16'h0, 32'h0, 1, 32'h0000_1515);
    chk("r039_lastack_done", 32'(bus.done), 32'h1);
    chk("r039_lastack_err",  32'(bus.err),  32'h0);
    idle_cyc();

    // Three back-to-back requests: two serviced, third dropped
    cyc(1, 0, 16'h8004, 32'h0, 0, 32'h0);
    cyc(1, 0, 16'h8008, 32'h0, 0, 32'h0);
    cyc(1, 0, 16'h800C, 32'h0, 0, 32'h0);
    chk("r040_overrun", 32'(bus.overrun),  32'h1);
    chk("r040_addr1",   32'(bus.dev_addr), 32'h0001);
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      cyc(0, 0, 16'h0, 32'h0, 1, 32'(i + 100));
      if (bus.done) dones++;
    end
    chk("r040_dones",  32'(dones),       32'h2);
    chk("r040_sticky", 32'(bus.overrun), 32'h1);

    // Reset in the middle of a device transfer
    cyc(1, 0, 16'h8010, 32'h0, 0, 32'h0);
    chk("r041_pre_req", 32'(bus.dev_req), 32'h1);
    do_reset("r041");
    cyc(1, 0, 16'h8014, 32'h0, 0, 32'h0);
    chk("r041_first_req", 32'(bus.dev_req), 32'h1);
    cyc(0, 0, 16'h0, 32'h0, 1, 32'h7777_0001);
    chk("r041_done",  32'(bus.done),  32'h1);
    chk("r041_wdata", bus.mem_wdata,  32'h7777_0001);
    idle_cyc();

    // Random traffic with varying ack density and occasional resets
    for (int i = 0; i < 3000; i++) begin
      if (i % 1000 == 999) do_reset("rnd_rst");
      case ((i / 250) % 3)
        0:       ack_div = 2;
        1:       ack_div = 8;
        default: ack_div = 40;
      endcase
      req = ($urandom_range(0, 2) == 0);
      dir = 1'($urandom_range(0, 1));
      md = 16'($urandom);
      md[15] = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 3) != 0) md[1:0] = 2'b00;
      ack = ($urandom_range(0, ack_div - 1) == 0);
      cyc(req, dir, md, $urandom, ack, $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/io_responder.md
IO_RESPONDER -- requirements
Module: io_responder

Interface
REQ-001 Parameter TIMEOUT, default 15: max cycles dev_req is held without dev_ack before abort (range 1..255).
REQ-002 clk  input  1  single clock; all state changes on posedge clk.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 IOrequest  input  1  one-cycle transfer request pulse from the program counter stage.
REQ-005 io_dir  input  1  0 = IO->memory, 1 = memory->IO; sampled with IOrequest.
REQ-006 move_data  input  16  IO byte address; sampled with IOrequest.
REQ-007 mem_rdata  input  32  word from memory to send to IO; sampled with IOrequest.
REQ-008 dev_req  output  1  request to IO device, held until ack or timeout.
REQ-009 dev_we  output  1  1 = device write, 0 = device read; valid while dev_req=1.
REQ-010 dev_addr  output  13  device word address.
REQ-011 dev_wdata  output  32  write data to device.
REQ-012 dev_ack  input  1  device completion, one-cycle pulse.
REQ-013 dev_rdata  input  32  device read data, valid with dev_ack.
REQ-014 mem_we  output  1  one-cycle write strobe of mem_wdata into memory.
REQ-015 mem_wdata  output  32  IO read data for memory.
REQ-016 busy  output  1  1 whenever state != IDLE or pending slot full.
REQ-017 done  output  1  one-cycle completion pulse per accepted request.
REQ-018 err  output  1  valid with done; 1 = rejected address or timeout.
REQ-019 overrun  output  1  sticky; set when a request is dropped.

Function
REQ-020 States: IDLE, REQ, CPL; encoding is implementation choice.
REQ-021 Address valid iff move_data[15]=1 and move_data[1:0]=0 (IO space above 8191*4); dev_addr = move_data[14:2].
REQ-022 IDLE with IOrequest=1 and valid address: latch io_dir, address, mem_rdata; next cycle REQ with dev_req=1, dev_we=io_dir, dev_wdata=latched data.
REQ-023 IDLE with IOrequest=1 and invalid address: no device access; next cycle CPL with done=1, err=1, mem_we=0.
REQ-024 REQ: dev_req, dev_we, dev_addr, dev_wdata stable until exit; timeout counter cleared on entry, increments each REQ cycle without dev_ack.
REQ-025 REQ with dev_ack=1: capture dev_rdata into mem_wdata when io_dir=0; next cycle CPL, dev_req=0.
REQ-026 REQ with counter = TIMEOUT-1 and dev_ack=0: next cycle CPL with err=1, dev_req=0, mem_we=0; dev_ack on the same cycle as the final count wins (no error).
REQ-027 CPL lasts exactly one cycle: done=1; mem_we=1 only if io_dir=0 and no error; mem_wdata holds until next capture.
REQ-028 Pending slot (depth 1): IOrequest while state != IDLE loads slot if empty; if full, request dropped, overrun set, no done for it.
REQ-029 CPL exit: slot full -> process slot exactly as REQ-022/023 (next state REQ or CPL), clear slot; else IDLE. IOrequest in the same CPL cycle as slot drain loads the freed slot.
REQ-030 dev_ack outside REQ is ignored.
REQ-031 Latency (valid, ack k cycles after dev_req rises, k>=0): done 2+k cycles after IOrequest.
REQ-032 overrun cleared only by reset.

Reset
REQ-033 rst_n=0 asynchronously forces IDLE, slot empty, counter 0, and dev_req, dev_we, dev_addr, dev_wdata, mem_we, mem_wdata, done, err, overrun, busy all 0.
REQ-034 Reset mid-transfer aborts it with no done pulse; requests before rst_n release are ignored.
REQ-035 First IOrequest accepted on the first posedge after rst_n rises.

Verification
REQ-036 io_dir=0, move_data=16'h8010, dev_ack next cycle with dev_rdata=32'hCAFE0001 -> dev_addr=13'h0004, dev_we=0; mem_we=1, mem_wdata=32'hCAFE0001, done=1, err=0, 3 cycles after IOrequest.
REQ-037 io_dir=1, move_data=16'hFFFC, mem_rdata=32'h12345678, ack after 2 cycles -> dev_we=1, dev_addr=13'h1FFF, dev_wdata=32'h12345678; done=1, mem_we=0.
REQ-038 move_data=16'h7FFC and 16'h8002 -> no dev_req; done=1, err=1 one cycle after each request.
REQ-039 TIMEOUT=15, no ack -> dev_req high exactly 15 cycles, then done=1, err=1; ack on cycle 15 -> err=0.
REQ-040 Three back-to-back IOrequest pulses -> two serviced in order with two done pulses, third dropped, overrun=1.
REQ-041 rst_n low while dev_req=1 -> all outputs 0 immediately, no done; next request completes normally.
